// File: rtl/br_predict.sv
// br_predict: fetch PC register with a direct-mapped 2-bit/target branch predictor,
// execute-stage resolution, mispredict redirect and statistics counters.
module br_predict #(
    parameter int XLEN = 32,
    parameter int IDX_W = 6,
    parameter int CNT_W = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pred_next,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic [2:0]       ex_br_op,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_imm,
    input  logic [XLEN-1:0]  ex_alu_out,
    input  logic             ex_lt,
    input  logic             ex_ltu,
    input  logic [XLEN-1:0]  ex_pred_next,
    output logic [XLEN-1:0]  ex_link,
    output logic             flush,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);
    localparam int TAG_W = XLEN - IDX_W - 2;
    localparam int N = 1 << IDX_W;
    localparam logic [2:0] BR_BEQ = 3'd0, BR_BNE = 3'd1, BR_BLT = 3'd2, BR_BLTU = 3'd3;
    localparam logic [2:0] BR_BGE = 3'd4, BR_BGEU = 3'd5, BR_JALR = 3'd6, BR_JAL = 3'd7;

    logic [XLEN-1:0]  pc_q, pc_d;
    logic             flush_q, flush_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;
    logic [1:0]       ctr_q [N];
    logic [1:0]       ctr_d [N];
    logic [N-1:0]     vld_q, vld_d;
    logic [TAG_W-1:0] tag_q [N];
    logic [TAG_W-1:0] tag_d [N];
    logic [XLEN-1:0]  tgt_q [N];
    logic [XLEN-1:0]  tgt_d [N];
    logic [IDX_W-1:0] r_idx, w_idx;
    logic [TAG_W-1:0] r_tag, w_tag;
    logic [XLEN-1:0]  actual;
    logic             taken, upd, mispred, miss;

    always_comb begin
        r_idx = pc_q[IDX_W+1:2];
        r_tag = pc_q[XLEN-1:IDX_W+2];
        pred_next = (vld_q[r_idx] && tag_q[r_idx] == r_tag && ctr_q[r_idx][1]) ? tgt_q[r_idx] : pc_q + XLEN'(4);
        ex_link = ex_pc + XLEN'(4);
        // jumps fall through to taken
        taken = (ex_br_op == BR_BEQ)  ? (ex_alu_out == '0) :
                (ex_br_op == BR_BNE)  ? (ex_alu_out != '0) :
                (ex_br_op == BR_BLT)  ? ex_lt :
                (ex_br_op == BR_BGE)  ? !ex_lt :
                (ex_br_op == BR_BLTU) ? ex_ltu :
                (ex_br_op == BR_BGEU) ? !ex_ltu : 1'b1;
        actual = !ex_branch ? ex_link :
                 (ex_br_op == BR_JAL)  ? ex_alu_out :
                 (ex_br_op == BR_JALR) ? {ex_alu_out[XLEN-1:1], 1'b0} :
                 taken ? ex_pc + ex_imm : ex_link;
        upd = ex_valid && ex_branch;
        mispred = ex_valid && actual != ex_pred_next;
        w_idx = ex_pc[IDX_W+1:2];
        w_tag = ex_pc[XLEN-1:IDX_W+2];
        miss = !vld_q[w_idx] || tag_q[w_idx] != w_tag;
        ctr_d = ctr_q;
        vld_d = vld_q;
        tag_d = tag_q;
        tgt_d = tgt_q;
        if (upd) begin
            ctr_d[w_idx] = miss ? (taken ? 2'd2 : 2'd1) :
                           taken ? (ctr_q[w_idx] == 2'd3 ? 2'd3 : ctr_q[w_idx] + 2'd1) :
                                   (ctr_q[w_idx] == 2'd0 ? 2'd0 : ctr_q[w_idx] - 2'd1);
            if (taken) begin
                vld_d[w_idx] = 1'b1;
                tag_d[w_idx] = w_tag;
                tgt_d[w_idx] = actual;
            end
        end
        pc_d = mispred ? actual : stall ? pc_q : pred_next;
        flush_d = mispred;
        br_cnt_d = br_cnt_q + CNT_W'(upd);
        mis_cnt_d = mis_cnt_q + CNT_W'(mispred);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_VEC;
            flush_q <= 1'b0;
            br_cnt_q <= '0;
            mis_cnt_q <= '0;
            ctr_q <= '{default: 2'd1};
            vld_q <= '0;
            tag_q <= '{default: '0};
            tgt_q <= '{default: '0};
        end else begin
            pc_q <= pc_d;
            flush_q <= flush_d;
            br_cnt_q <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
            ctr_q <= ctr_d;
            vld_q <= vld_d;
            tag_q <= tag_d;
            tgt_q <= tgt_d;
        end
    end

    assign pc = pc_q;
    assign flush = flush_q;
    assign br_count = br_cnt_q;
    assign mispred_count = mis_cnt_q;
endmodule

// File: tb/tb_br_predict.sv
// tb_br_predict: directed vectors for br_predict; expectations queued at issue, checked by a monitor.
module tb_br_predict;
    localparam logic [2:0] BEQ = 3'd0, BNE = 3'd1, BLT = 3'd2, BLTU = 3'd3;
    localparam logic [2:0] BGE = 3'd4, BGEU = 3'd5, JALR = 3'd6;

    typedef struct {
        string       nm;
        logic [31:0] pc, pred, br, mis, link;
        logic        fl, cl;
    } exp_t;

    logic        clk, rst_n, stall;
    logic [31:0] pc, pred_next, ex_pc, ex_imm, ex_alu_out, ex_pred_next, ex_link;
    logic        ex_valid, ex_branch, ex_lt, ex_ltu, flush;
    logic [2:0]  ex_br_op;
    logic [31:0] br_count, mispred_count;
    exp_t        q[$];
    int          vectors = 0;
    int          miscompares = 0;

    br_predict dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .pc(pc), .pred_next(pred_next),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_br_op(ex_br_op), .ex_pc(ex_pc),
        .ex_imm(ex_imm), .ex_alu_out(ex_alu_out), .ex_lt(ex_lt), .ex_ltu(ex_ltu),
        .ex_pred_next(ex_pred_next), .ex_link(ex_link), .flush(flush),
        .br_count(br_count), .mispred_count(mispred_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string what, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s.%s got=%h want=%h", nm, what, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk(e.nm, "pc", pc, e.pc);
                chk(e.nm, "flush", {31'd0, flush}, {31'd0, e.fl});
                chk(e.nm, "pred_next", pred_next, e.pred);
                chk(e.nm, "br_count", br_count, e.br);
                chk(e.nm, "mispred_count", mispred_count, e.mis);
                if (e.cl) chk(e.nm, "ex_link", ex_link, e.link);
            end
        end
    end

    task automatic push(input string nm, input logic [31:0] p, input logic f, input logic [31:0] b,
                        input logic [31:0] m, input logic [31:0] pr, input logic cl, input logic [31:0] lk);
        exp_t e;
        e.nm = nm; e.pc = p; e.fl = f; e.br = b; e.mis = m; e.pred = pr; e.cl = cl; e.link = lk;
        q.push_back(e);
    endtask

    task automatic tick(input string nm, input logic [31:0] p, input logic f, input logic [31:0] b,
                        input logic [31:0] m, input logic [31:0] pr, input logic cl, input logic [31:0] lk);
        push(nm, p, f, b, m, pr, cl, lk);
        @(negedge clk);
    endtask

    task automatic idle();
        ex_valid = 1'b0;
        ex_branch = 1'b0;
    endtask

    task automatic res(input logic br, input logic [2:0] op, input logic [31:0] epc, input logic [31:0] imm,
                       input logic [31:0] alu, input logic lt, input logic ltu, input logic [31:0] ep);
        ex_valid = 1'b1; ex_branch = br; ex_br_op = op; ex_pc = epc; ex_imm = imm;
        ex_alu_out = alu; ex_lt = lt; ex_ltu = ltu; ex_pred_next = ep;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0;
        res(1'b0, BEQ, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        idle();
        @(negedge clk);
        tick("rst", 32'h0, 0, 0, 0, 32'h4, 0, 0);
        rst_n = 1'b1;
        tick("seq4", 32'h4, 0, 0, 0, 32'h8, 0, 0);
        tick("seq8", 32'h8, 0, 0, 0, 32'hc, 0, 0);
        tick("seq12", 32'hc, 0, 0, 0, 32'h10, 0, 0);
        stall = 1'b1;
        repeat (3) tick("stall_hold", 32'hc, 0, 0, 0, 32'h10, 0, 0);
        stall = 1'b0;
        res(1'b1, BEQ, 32'h40, 32'h20, 32'h0, 1'b0, 1'b0, 32'h44);
        tick("beq_first", 32'h60, 1, 1, 1, 32'h64, 1, 32'h44);
        idle();
        tick("beq_pulse_end", 32'h64, 0, 1, 1, 32'h68, 0, 0);
        res(1'b1, BEQ, 32'h40, 32'h20, 32'h0, 1'b0, 1'b0, 32'h60);
        tick("beq_second", 32'h68, 0, 2, 1, 32'h6c, 1, 32'h44);
        res(1'b0, BEQ, 32'h3c, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick("redir_40", 32'h40, 1, 2, 2, 32'h60, 1, 32'h40);
        idle();
        tick("follow_pred", 32'h60, 0, 2, 2, 32'h64, 0, 0);
        res(1'b1, BLTU, 32'h100, 32'h8, 32'h0, 1'b0, 1'b1, 32'h104);
        tick("bltu", 32'h108, 1, 3, 3, 32'h10c, 1, 32'h104);
        res(1'b1, BGEU, 32'h100, 32'h8, 32'h0, 1'b0, 1'b1, 32'h104);
        tick("bgeu", 32'h10c, 0, 4, 3, 32'h110, 1, 32'h104);
        res(1'b1, JALR, 32'h200, 32'h0, 32'h203, 1'b0, 1'b0, 32'h204);
        tick("jalr_miss", 32'h202, 1, 5, 4, 32'h202, 1, 32'h204);
        res(1'b1, JALR, 32'h200, 32'h0, 32'h203, 1'b0, 1'b0, 32'h202);
        tick("jalr_hit", 32'h202, 0, 6, 4, 32'h202, 1, 32'h204);
        stall = 1'b1;
        res(1'b1, BNE, 32'h300, 32'h10, 32'h5, 1'b0, 1'b0, 32'h304);
        tick("stall_redir", 32'h310, 1, 7, 5, 32'h314, 1, 32'h304);
        stall = 1'b0;
        res(1'b1, BLT, 32'h400, 32'h40, 32'h0, 1'b1, 1'b0, 32'h404);
        tick("blt_b2b", 32'h440, 1, 8, 6, 32'h444, 1, 32'h404);
        res(1'b1, BGE, 32'h500, 32'h40, 32'h0, 1'b1, 1'b0, 32'h504);
        tick("bge_nt", 32'h444, 0, 9, 6, 32'h448, 1, 32'h504);
        res(1'b1, BEQ, 32'h80, 32'h40, 32'h0, 1'b0, 1'b0, 32'hc0);
        tick("sat_t1", 32'h448, 0, 10, 6, 32'h44c, 1, 32'h84);
        tick("sat_t2", 32'h44c, 0, 11, 6, 32'h450, 1, 32'h84);
        tick("sat_t3", 32'h450, 0, 12, 6, 32'h454, 1, 32'h84);
        tick("sat_t4", 32'h454, 0, 13, 6, 32'h458, 1, 32'h84);
        res(1'b0, BEQ, 32'h7c, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick("redir_80", 32'h80, 1, 13, 7, 32'hc0, 1, 32'h80);
        stall = 1'b1;
        res(1'b1, BEQ, 32'h80, 32'h40, 32'h1, 1'b0, 1'b0, 32'h84);
        tick("sat_nt1", 32'h80, 0, 14, 7, 32'hc0, 1, 32'h84);
        tick("sat_nt2", 32'h80, 0, 15, 7, 32'h84, 1, 32'h84);
        tick("sat_nt3", 32'h80, 0, 16, 7, 32'h84, 1, 32'h84);
        tick("sat_nt4", 32'h80, 0, 17, 7, 32'h84, 1, 32'h84);
        tick("sat_nt5", 32'h80, 0, 18, 7, 32'h84, 1, 32'h84);
        res(1'b1, BEQ, 32'h80, 32'h40, 32'h0, 1'b0, 1'b0, 32'hc0);
        tick("sat0_t", 32'h80, 0, 19, 7, 32'h84, 1, 32'h84);
        stall = 1'b0;
        // a redirect in flight when reset lands must be discarded
        res(1'b0, BEQ, 32'h1000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        push("rst_mid", 32'h0, 0, 0, 0, 32'h4, 0, 0);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        tick("post_rst", 32'h4, 0, 0, 0, 32'h8, 0, 0);
        res(1'b0, BEQ, 32'h3c, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick("tbl_clr", 32'h40, 1, 0, 1, 32'h44, 1, 32'h40);
        idle();
        tick("end", 32'h44, 0, 0, 1, 32'h48, 0, 0);
        repeat (2) @(negedge clk);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got=%0d want=0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
